// File: rtl/div_share_pkg.sv
// Shared types and width helpers for the shared-divider scheduler.
package div_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < v) r++;
        return r;
    endfunction

    // Settle counter must hold the value SETTLE_CYCLES itself.
    function automatic int cnt_width(input int settle);
        return clog2(settle + 1);
    endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = IDW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one combinational unsigned divider among NUM_REQ requesters.
// Optional DIV_SHARE_ZERO_FAST_EN: zero divider skips the settle window (latency 1).
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                            Clk,
    input  logic                            nReset,
    input  logic [NUM_REQ-1:0]              ReqValid,
    output logic [NUM_REQ-1:0]              ReqReady,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   ReqDividend,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   ReqDivider,
    output logic                            RespValid,
    input  logic                            RespReady,
    output logic [clog2(NUM_REQ)-1:0]       RespId,
    output logic [DATA_WIDTH-1:0]           Quotient,
    output logic [DATA_WIDTH-1:0]           Remainder,
    output logic                            DivByZero
);

    localparam int IDW = clog2(NUM_REQ);
    localparam int CW  = cnt_width(SETTLE_CYCLES);

    state_t                 state;
    logic [IDW-1:0]         ptr, op_id, gnt_idx;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-1:0]  op_a, op_b, req_a, req_b;
    logic [DATA_WIDTH-1:0]  safe_b, core_q, core_r;
    logic [NUM_REQ-1:0]     gnt;
    logic                   gnt_any;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
        .req   (ReqValid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Held low during reset so a pending request is never shown a grant.
    assign ReqReady = (state == IDLE && nReset) ? gnt : '0;
    assign req_a    = ReqDividend[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign req_b    = ReqDivider[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // Divider core; the zero case is replaced at the result register.
    always_comb begin
        safe_b = (op_b == '0) ? DATA_WIDTH'(1) : op_b;
        core_q = op_a / safe_b;
        core_r = op_a % safe_b;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            RespValid <= 1'b0;
            RespId    <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a  <= req_a;
                        op_b  <= req_b;
                        op_id <= gnt_idx;
                        ptr   <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state <= SETTLE;
`ifdef DIV_SHARE_ZERO_FAST_EN
                        cnt   <= (req_b == '0) ? CW'(1) : CW'(SETTLE_CYCLES);
`else
                        cnt   <= CW'(SETTLE_CYCLES);
`endif
                    end
                end
                SETTLE: begin
                    if (cnt == CW'(1)) begin
                        RespValid <= 1'b1;
                        RespId    <= op_id;
                        Quotient  <= (op_b == '0) ? '1   : core_q;
                        Remainder <= (op_b == '0) ? op_a : core_r;
                        DivByZero <= (op_b == '0);
                        cnt       <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: stimulus pushes expected results, a monitor pops on handshake.
module tb_div_share_ctrl;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SC = 2;
`ifdef DIV_SHARE_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = SC;
`endif

    logic              Clk = 1'b0;
    logic              nReset;
    logic [NR-1:0]     ReqValid;
    logic [NR-1:0]     ReqReady;
    logic [NR*DW-1:0]  ReqDividend, ReqDivider;
    logic              RespValid, RespReady;
    logic [1:0]        RespId;
    logic [DW-1:0]     Quotient, Remainder;
    logic              DivByZero;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    div_share_ctrl #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
        .Clk(Clk), .nReset(nReset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqDividend(ReqDividend), .ReqDivider(ReqDivider), .RespValid(RespValid),
        .RespReady(RespReady), .RespId(RespId), .Quotient(Quotient),
        .Remainder(Remainder), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (nReset && RespValid && RespReady) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got id=%0d q=%0d r=%0d dbz=%0b expected none",
                         RespId, Quotient, Remainder, DivByZero);
            end else begin
                chk("resp {id,q,r,dbz}", {RespId, Quotient, Remainder, DivByZero}, exp_q.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        ReqDividend[i*DW +: DW] = a;
        ReqDivider[i*DW +: DW]  = b;
        ReqValid[i]             = 1'b1;
    endtask

    task automatic push(input int id, input int q, input int r, input int dbz);
        exp_t e;
        e.id = 2'(id); e.q = 8'(q); e.r = 8'(r); e.dbz = 1'(dbz);
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for a grant and checks it is the expected one-hot; returns just before the accept edge.
    task automatic wait_grant(input int i);
        int c;
        logic [NR-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        @(negedge Clk);
        c = 0;
        while (ReqReady == '0 && c < 30) begin
            @(negedge Clk);
            c++;
        end
        chk($sformatf("grant%0d", i), 32'(ReqReady), 32'(oh));
    endtask

    // Called just after the accept edge: RespValid low for lat cycles, then high.
    task automatic chk_latency(input string name, input int lat);
        for (int c = 0; c < lat; c++) begin
            @(negedge Clk);
            chk({name, "_pre"}, 32'(RespValid), 32'd0);
        end
        @(negedge Clk);
        chk({name, "_valid"}, 32'(RespValid), 32'd1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 60) begin
            @(posedge Clk);
            c++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge Clk); #1;
    endtask

    task automatic pulse_reset();
        ReqValid = '0;
        nReset   = 1'b0;
        @(posedge Clk); #1;
        nReset   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        nReset      = 1'b0;
        ReqValid    = '0;
        ReqDividend = '0;
        ReqDivider  = '0;
        RespReady   = 1'b1;
        #3;
        chk("rst_ready", 32'(ReqReady), 32'd0);
        chk("rst_outs", {RespValid, RespId, Quotient, Remainder, DivByZero}, 32'd0);
        @(posedge Clk); #1;
        nReset = 1'b1;

        // 1: single request 13/2
        set_req(0, 8'd13, 8'd2);
        push(0, 6, 1, 0);
        wait_grant(0);
        @(posedge Clk); #1;
        ReqValid[0] = 1'b0;
        chk("t1_ready_once", 32'(ReqReady), 32'd0);
        chk_latency("t1_lat", SC);
        drain();

        // 2: all four held, pointer from 0
        pulse_reset();
        set_req(0, 8'd255, 8'd1);
        set_req(1, 8'd7,   8'd9);
        set_req(2, 8'd100, 8'd10);
        set_req(3, 8'd9,   8'd4);
        push(0, 255, 0, 0); wait_grant(0); @(posedge Clk); #1;
        push(1, 0, 7, 0);   wait_grant(1); @(posedge Clk); #1;
        push(2, 10, 0, 0);  wait_grant(2); @(posedge Clk); #1;
        push(3, 2, 1, 0);   wait_grant(3); @(posedge Clk); #1;
        push(0, 255, 0, 0); wait_grant(0); @(posedge Clk); #1;
        ReqValid = '0;
        drain();

        // 3: divide by zero
        set_req(2, 8'd200, 8'd0);
        push(2, 255, 200, 1);
        wait_grant(2);
        @(posedge Clk); #1;
        ReqValid[2] = 1'b0;
        chk_latency("t3_lat", ZLAT);
        drain();

        // 4: back-pressure with req1 pending
        RespReady = 1'b0;
        set_req(0, 8'd13, 8'd2);
        push(0, 6, 1, 0);
        wait_grant(0);
        @(posedge Clk); #1;
        ReqValid[0] = 1'b0;
        set_req(1, 8'd7, 8'd9);
        push(1, 0, 7, 0);
        repeat (SC) @(posedge Clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            chk("t4_hold", {RespValid, RespId, Quotient, Remainder, DivByZero},
                {1'b1, 2'd0, 8'd6, 8'd1, 1'b0});
            chk("t4_noready", 32'(ReqReady), 32'd0);
        end
        @(posedge Clk); #1;
        RespReady = 1'b1;
        @(negedge Clk);
        chk("t4_hs_noready", 32'(ReqReady), 32'd0);
        @(negedge Clk);
        chk("t4_idle_grant", 32'(ReqReady), 32'b0010);
        chk("t4_resp_low", 32'(RespValid), 32'd0);
        @(posedge Clk); #1;
        ReqValid[1] = 1'b0;
        drain();

        // 5: reset mid-SETTLE drops the operation and clears the pointer
        set_req(3, 8'd11, 8'd3);
        set_req(0, 8'd20, 8'd6);
        wait_grant(3);
        @(posedge Clk); #1;
        @(negedge Clk);
        nReset = 1'b0;
        #1;
        chk("t5_rst_outs", {RespValid, RespId, Quotient, Remainder, DivByZero}, 32'd0);
        chk("t5_rst_ready", 32'(ReqReady), 32'd0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        nReset = 1'b1;
        push(0, 3, 2, 0);
        wait_grant(0);
        @(posedge Clk); #1;
        ReqValid[0] = 1'b0;
        push(3, 3, 2, 0);
        wait_grant(3);
        @(posedge Clk); #1;
        ReqValid[3] = 1'b0;
        drain();

        // 6: operands changed after accept are not used for the in-flight op
        set_req(1, 8'd13, 8'd2);
        push(1, 6, 1, 0);
        wait_grant(1);
        @(posedge Clk); #1;
        set_req(1, 8'd50, 8'd5);
        push(1, 10, 0, 0);
        wait_grant(1);
        @(posedge Clk); #1;
        ReqValid[1] = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
